cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares the single request port of the directMapped L1/L2 cache between two requesters.
//  Requester 0 is instruction fetch; requester 1 is load/store.
//  Round-robin arbitration; one transaction in flight; miss/request statistics counters.
//  Sits between the CPU-side ports and the cache's ivalid/iRW/iaddress/oready interface.
// PARAMETERS
//  ADDR_W    11   address width (2 KiB space)
//  DATA_W    8    data width
//  CNT_W     16   width of the statistics counters
//  MAX_WAIT  255  cycles in WAIT without c_done before timeout (>=1)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous reset, active-low
//  rN_valid       in   1       requester N (N=0,1) request valid
//  rN_ready       out  1       requester N accept; transfer = valid & ready at posedge
//  rN_RW          in   1       0 = read, 1 = write
//  rN_address     in   ADDR_W  request address
//  rN_write_data  in   DATA_W  write data
//  rN_rvalid      out  1       one-cycle response (read data or write ack)
//  rN_read_data   out  DATA_W  response data; 0 for writes and timeouts
//  c_valid        out  1       request to cache (drives cache ivalid)
//  c_ready        in   1       cache accepted request
//  c_RW           out  1       latched RW
//  c_address      out  ADDR_W  latched address
//  c_write_data   out  DATA_W  latched write data
//  c_done         in   1       cache completed access (cache oready)
//  c_read_data    in   DATA_W  cache read data, valid with c_done
//  L1miss         in   1       cache L1 miss flag, sampled with c_done
//  L2miss         in   1       cache L2 miss flag, sampled with c_done
//  clr_stats      in   1       synchronous clear of counters and timeout flag
//  req_cnt        out  CNT_W   accepted requests
//  l1_miss_cnt    out  CNT_W   completed accesses with L1miss=1
//  l2_miss_cnt    out  CNT_W   completed accesses with L2miss=1
//  timeout        out  1       sticky flag: a WAIT timed out
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM goes to IDLE; last_grant=1, so r0 is preferred first.
//   - All registered outputs, counters, timeout and latches go to 0; c_valid drops immediately.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//  IDLE:
//   - rN_ready is combinational: high only for the selected requester.
//   - One valid requester: it is selected.
//   - Both valid: select the one not equal to last_grant.
//   - On transfer: latch RW/address/write_data and owner; last_grant<=owner; req_cnt++; go ISSUE.
//  ISSUE:
//   - c_valid=1; c_RW/c_address/c_write_data stay stable until c_ready.
//   - On c_ready: go WAIT and clear the wait counter.
//  WAIT:
//   - c_valid=0. c_done is only honoured in WAIT; c_done in other states is ignored.
//   - On c_done: latch c_read_data (0 if write); L1miss=1 -> l1_miss_cnt++; L2miss=1 -> l2_miss_cnt++
//     (independent); go RESP.
//   - Else wait counter++. On reaching MAX_WAIT: timeout<=1, response data 0, go RESP.
//  RESP:
//   - Owner's rN_rvalid=1 for exactly one cycle with rN_read_data; no backpressure.
//   - Go IDLE. rN_read_data holds its value until the next response.
//  rN_ready is always 0 outside IDLE, so there is no re-arbitration mid-transaction.
//  Minimum latency (c_ready in ISSUE, c_done first WAIT cycle):
//   - accept at posedge T, c_valid during T..T+1, rvalid in cycle T+3; 4 cycles per transaction.
//  Counters saturate at all-ones, never wrap; widths are exactly CNT_W.
//  clr_stats wins over a same-cycle increment (result 0) and clears timeout.
//  Reset mid-transaction abandons it: no rvalid, no counter update.
// TESTING
//  1 rst_n=0 mid-ISSUE -> c_valid=0 same cycle; after release, r1-only request granted normally.
//  2 r0 read 11'h451, c_ready at once, c_done next cycle with 8'hA5
//    -> r0_rvalid one cycle with 8'hA5, r1_rvalid=0, req_cnt=1.
//  3 r0,r1 valid continuously for 4 transactions -> grant order r0,r1,r0,r1; never two in flight.
//  4 Completion with L1miss=1,L2miss=1, then one with L1miss=1,L2miss=0 -> l1=2, l2=1;
//    clr_stats on a c_done cycle -> both 0.
//  5 r1 write 11'h6A2 data 8'h3C, c_done withheld -> after MAX_WAIT cycles timeout=1,
//    r1_rvalid with 8'h00, FSM back in IDLE.
//  6 CNT_W=2, 5 requests -> req_cnt saturates at 3.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the arbiter's requester ports, cache-side port and statistics outputs.
// slave : view taken by cache_port_arbiter itself.
// master: view of the environment (CPU requesters, the cache and the stats reader).
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  // requester 0 (instruction fetch)
  logic              r0_valid;
  logic              r0_ready;
  logic              r0_RW;
  logic [ADDR_W-1:0] r0_address;
  logic [DATA_W-1:0] r0_write_data;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_read_data;
  // requester 1 (load/store)
  logic              r1_valid;
  logic              r1_ready;
  logic              r1_RW;
  logic [ADDR_W-1:0] r1_address;
  logic [DATA_W-1:0] r1_write_data;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_read_data;
  // cache side
  logic              c_valid;
  logic              c_ready;
  logic              c_RW;
  logic [ADDR_W-1:0] c_address;
  logic [DATA_W-1:0] c_write_data;
  logic              c_done;
  logic [DATA_W-1:0] c_read_data;
  logic              L1miss;
  logic              L2miss;
  // statistics
  logic              clr_stats;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  l1_miss_cnt;
  logic [CNT_W-1:0]  l2_miss_cnt;
  logic              timeout;

  modport slave (
    input  r0_valid, r0_RW, r0_address, r0_write_data,
    output r0_ready, r0_rvalid, r0_read_data,
    input  r1_valid, r1_RW, r1_address, r1_write_data,
    output r1_ready, r1_rvalid, r1_read_data,
    output c_valid, c_RW, c_address, c_write_data,
    input  c_ready, c_done, c_read_data, L1miss, L2miss,
    input  clr_stats,
    output req_cnt, l1_miss_cnt, l2_miss_cnt, timeout
  );

  modport master (
    output r0_valid, r0_RW, r0_address, r0_write_data,
    input  r0_ready, r0_rvalid, r0_read_data,
    output r1_valid, r1_RW, r1_address, r1_write_data,
    input  r1_ready, r1_rvalid, r1_read_data,
    input  c_valid, c_RW, c_address, c_write_data,
    output c_ready, c_done, c_read_data, L1miss, L2miss,
    output clr_stats,
    input  req_cnt, l1_miss_cnt, l2_miss_cnt, timeout
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Purpose : round-robin share of the single cache request port between fetch (r0) and load/store (r1).
// Latency : accept at edge T, c_valid for one cycle at best, rvalid 3 cycles after accept; 4 cycles per transaction.
// Backpress: rN_ready only in IDLE for the selected requester; cache back-pressures via c_ready; no response backpressure.
// Ports   : clk, rst_n (async, active-low); bus (slave modport) carries both requester ports,
//           the cache ivalid/iRW/iaddress/oready interface, miss flags and the statistics counters.
module cache_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_port_arbiter_if.slave   bus
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_c_valid;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [CNT_W-1:0]    r_req_cnt;
  logic [CNT_W-1:0]    r_l1_cnt;
  logic [CNT_W-1:0]    r_l2_cnt;
  logic                r_timeout;

  logic                w_idle;
  logic                w_sel1;
  logic                w_xfer;
  logic                w_done;
  logic                w_tmo;
  logic [DATA_W-1:0]   w_resp_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_idle = (r_state == S_IDLE);
  // r1 wins when it is alone, or when both ask and r0 was served last.
  assign w_sel1 = bus.r1_valid & (~bus.r0_valid | ~r_last_grant);
  assign w_xfer = w_idle & (bus.r0_valid | bus.r1_valid);
  assign w_done = (r_state == S_WAIT) & bus.c_done;
  // The MAX_WAIT-th WAIT cycle without c_done ends the wait.
  assign w_tmo  = (r_state == S_WAIT) & ~bus.c_done & (r_wait_cnt == WCNT_W'(MAX_WAIT - 1));
  // Writes and timeouts answer with zero data.
  assign w_resp_data = (w_done & ~r_rw) ? bus.c_read_data : '0;

  assign bus.r0_ready     = w_idle & bus.r0_valid & ~w_sel1;
  assign bus.r1_ready     = w_idle & w_sel1;
  assign bus.r0_rvalid    = r_rvalid0;
  assign bus.r1_rvalid    = r_rvalid1;
  assign bus.r0_read_data = r_rdata0;
  assign bus.r1_read_data = r_rdata1;
  assign bus.c_valid      = r_c_valid;
  assign bus.c_RW         = r_rw;
  assign bus.c_address    = r_addr;
  assign bus.c_write_data = r_wdata;
  assign bus.req_cnt      = r_req_cnt;
  assign bus.l1_miss_cnt  = r_l1_cnt;
  assign bus.l2_miss_cnt  = r_l2_cnt;
  assign bus.timeout      = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_c_valid    <= 1'b0;
      r_wait_cnt   <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_req_cnt    <= '0;
      r_l1_cnt     <= '0;
      r_l2_cnt     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      // Responses are single-cycle pulses.
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_owner      <= w_sel1;
            r_last_grant <= w_sel1;
            r_rw         <= w_sel1 ? bus.r1_RW         : bus.r0_RW;
            r_addr       <= w_sel1 ? bus.r1_address    : bus.r0_address;
            r_wdata      <= w_sel1 ? bus.r1_write_data : bus.r0_write_data;
            r_c_valid    <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.c_ready) begin
            r_c_valid  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done || w_tmo) begin
            if (r_owner) begin
              r_rvalid1 <= 1'b1;
              r_rdata1  <= w_resp_data;
            end else begin
              r_rvalid0 <= 1'b1;
              r_rdata0  <= w_resp_data;
            end
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Clear takes priority over any same-cycle increment.
      if (bus.clr_stats) begin
        r_req_cnt <= '0;
        r_l1_cnt  <= '0;
        r_l2_cnt  <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_xfer) r_req_cnt <= sat_inc(r_req_cnt);
        if (w_done && bus.L1miss) r_l1_cnt <= sat_inc(r_l1_cnt);
        if (w_done && bus.L2miss) r_l2_cnt <= sat_inc(r_l2_cnt);
        if (w_tmo) r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus a randomized phase, checked against a
// transaction-level model (one-in-flight round robin, cache responder, counter expectations).
// A second instance with 2-bit counters shares all stimulus to exercise saturation.
module tb_cache_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) bus ();
  cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2))  bus_s ();

  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16), .MAX_WAIT(MAX_WAIT))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2), .MAX_WAIT(MAX_WAIT))
    u_dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.r0_valid      = bus.r0_valid;
  assign bus_s.r0_RW         = bus.r0_RW;
  assign bus_s.r0_address    = bus.r0_address;
  assign bus_s.r0_write_data = bus.r0_write_data;
  assign bus_s.r1_valid      = bus.r1_valid;
  assign bus_s.r1_RW         = bus.r1_RW;
  assign bus_s.r1_address    = bus.r1_address;
  assign bus_s.r1_write_data = bus.r1_write_data;
  assign bus_s.c_ready       = bus.c_ready;
  assign bus_s.c_done        = bus.c_done;
  assign bus_s.c_read_data   = bus.c_read_data;
  assign bus_s.L1miss        = bus.L1miss;
  assign bus_s.L2miss        = bus.L2miss;
  assign bus_s.clr_stats     = bus.clr_stats;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int satv(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- model state ----------------
  bit              busy, issuing, m_last, m_owner, m_rw, rsp_due;
  logic [10:0]     m_addr;
  logic [7:0]      m_wdata, rsp_data;
  logic [7:0]      last_data [2];
  int              exp_req, exp_l1, exp_l2;
  bit              exp_to;
  int              cyc, rsp_cnt, rdy_cyc;
  bit              acc_flag [2];
  // timestamps and grant order as observed on the DUT pins
  bit              dut_gq[$];
  int              dut_gcyc[$];
  int              dut_rv_cyc;
  // responder state and knobs
  int              ph, cnt;
  int              ready_dly, done_dly;
  bit              done_en, stray_en, rnd_mode, fix_data, fix_miss, l1_val, l2_val;
  logic [7:0]      fix_val;
  bit              clr_req, clr_on_done;
  // per-cycle scratch
  bit              n_gnt, n_sel, n_l1, n_l2, n_to, n_clr, n_done;
  logic [7:0]      n_d;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk_eq("rst_c_valid", bus.c_valid, 0);
      chk_eq("rst_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      chk_eq("rst_req_cnt", bus.req_cnt, 0);
      chk_eq("rst_timeout", bus.timeout, 0);
      busy = 0; issuing = 0; rsp_due = 0; m_last = 1; ph = 0; cnt = 0;
      exp_req = 0; exp_l1 = 0; exp_l2 = 0; exp_to = 0;
      last_data[0] = '0; last_data[1] = '0;
      bus.c_ready = 0; bus.c_done = 0; bus.L1miss = 0; bus.L2miss = 0;
      bus.c_read_data = '0; bus.clr_stats = 0;
    end else begin
      // ---- compare DUT against the model state reached after the last edge ----
      n_gnt = !busy && (bus.r0_valid || bus.r1_valid);
      n_sel = (bus.r0_valid && bus.r1_valid) ? !m_last : bus.r1_valid;
      chk_eq("r0_ready", bus.r0_ready, n_gnt && !n_sel);
      chk_eq("r1_ready", bus.r1_ready, n_gnt && n_sel);
      chk_eq("c_valid", bus.c_valid, issuing);
      if (issuing) begin
        chk_eq("c_RW", bus.c_RW, m_rw);
        chk_eq("c_address", bus.c_address, m_addr);
        chk_eq("c_write_data", bus.c_write_data, m_wdata);
      end
      chk_eq("r0_rvalid", bus.r0_rvalid, rsp_due && !m_owner);
      chk_eq("r1_rvalid", bus.r1_rvalid, rsp_due && m_owner);
      if (rsp_due) begin
        last_data[m_owner] = rsp_data;
        rsp_cnt++;
        busy = 0;
        rsp_due = 0;
      end
      chk_eq("r0_read_data", bus.r0_read_data, last_data[0]);
      chk_eq("r1_read_data", bus.r1_read_data, last_data[1]);
      chk_eq("req_cnt", bus.req_cnt, satv(exp_req, 65535));
      chk_eq("req_cnt_sat", bus_s.req_cnt, satv(exp_req, 3));
      chk_eq("l1_miss_cnt", bus.l1_miss_cnt, satv(exp_l1, 65535));
      chk_eq("l2_miss_cnt", bus.l2_miss_cnt, satv(exp_l2, 65535));
      chk_eq("timeout", bus.timeout, exp_to);

      // ---- pin-level observations ----
      if (bus.r0_valid && bus.r0_ready) begin dut_gq.push_back(1'b0); dut_gcyc.push_back(cyc); end
      if (bus.r1_valid && bus.r1_ready) begin dut_gq.push_back(1'b1); dut_gcyc.push_back(cyc); end
      if (bus.r0_rvalid || bus.r1_rvalid) dut_rv_cyc = cyc;

      // ---- grant happens at the coming edge ----
      if (n_gnt) begin
        busy = 1; issuing = 1; m_owner = n_sel; m_last = n_sel;
        m_rw    = n_sel ? bus.r1_RW         : bus.r0_RW;
        m_addr  = n_sel ? bus.r1_address    : bus.r0_address;
        m_wdata = n_sel ? bus.r1_write_data : bus.r0_write_data;
        acc_flag[n_sel] = 1;
      end

      // ---- cache responder ----
      bus.c_ready = 0; bus.c_done = 0; bus.L1miss = 0; bus.L2miss = 0;
      bus.c_read_data = 8'($urandom);
      n_l1 = 0; n_l2 = 0; n_to = 0; n_done = 0;
      if (ph == 0 && bus.c_valid) begin
        if (rnd_mode) begin
          ready_dly = $urandom_range(0, 3);
          done_dly  = $urandom_range(0, 3);
        end
        cnt = ready_dly;
        ph = 2;
      end
      if (ph == 2) begin
        if (cnt == 0) begin
          bus.c_ready = 1; issuing = 0; rdy_cyc = cyc; ph = 1;
          cnt = done_en ? done_dly : MAX_WAIT - 1;
        end else cnt--;
      end else if (ph == 1) begin
        if (cnt == 0) begin
          if (done_en) begin
            n_d  = fix_data ? fix_val : 8'($urandom);
            n_l1 = fix_miss ? l1_val : 1'($urandom);
            n_l2 = fix_miss ? l2_val : 1'($urandom);
            bus.c_done = 1; bus.c_read_data = n_d; bus.L1miss = n_l1; bus.L2miss = n_l2;
            rsp_data = m_rw ? 8'h00 : n_d;
            n_done = 1;
          end else begin
            rsp_data = 8'h00;
            n_to = 1;
          end
          rsp_due = 1;
          ph = 0;
        end else cnt--;
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        // completion outside WAIT must have no effect
        bus.c_done = 1; bus.L1miss = 1; bus.L2miss = 1;
      end

      // ---- statistics expectations for the coming edge ----
      n_clr = clr_req || (clr_on_done && n_done);
      clr_req = 0;
      bus.clr_stats = n_clr;
      if (n_clr) begin
        exp_req = 0; exp_l1 = 0; exp_l2 = 0; exp_to = 0;
      end else begin
        if (n_gnt) exp_req++;
        if (n_l1) exp_l1++;
        if (n_l2) exp_l2++;
        if (n_to) exp_to = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input bit who, input bit v, input bit rw, input logic [10:0] a, input logic [7:0] d);
    if (who) begin
      bus.r1_valid = v; bus.r1_RW = rw; bus.r1_address = a; bus.r1_write_data = d;
    end else begin
      bus.r0_valid = v; bus.r0_RW = rw; bus.r0_address = a; bus.r0_write_data = d;
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (dut_gq.size() < n && k < budget) begin @(posedge clk); k++; end
    if (dut_gq.size() < n) chk_eq("wait_grant_expired", dut_gq.size(), n);
    #1;
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int k = 0;
    while (rsp_cnt < n && k < budget) begin @(posedge clk); k++; end
    if (rsp_cnt < n) chk_eq("wait_rsp_expired", rsp_cnt, n);
    #1;
  endtask

  task automatic send_req(input bit who, input bit rw, input logic [10:0] a, input logic [7:0] d);
    int g = dut_gq.size() + 1;
    int r = rsp_cnt + 1;
    set_req(who, 1'b1, rw, a, d);
    wait_grants(g, 50);
    set_req(who, 1'b0, 1'b0, '0, '0);
    wait_rsps(r, MAX_WAIT + 50);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  bit exp_order [4];
  int base;

  initial begin
    rst_n = 0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    ready_dly = 0; done_dly = 0; done_en = 1; stray_en = 0; rnd_mode = 0;
    fix_data = 1; fix_val = 8'hA5; fix_miss = 1; l1_val = 0; l2_val = 0;
    clr_req = 0; clr_on_done = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // minimum-latency read by r0
    send_req(1'b0, 1'b0, 11'h451, 8'h00);
    chk_eq("t2_rdata", bus.r0_read_data, 8'hA5);
    chk_eq("t2_latency", dut_rv_cyc - dut_gcyc[$], 3);
    chk_eq("t2_req_cnt", bus.req_cnt, 1);

    // both requesters continuously valid: alternation, one in flight
    do_reset();
    base = dut_gq.size();
    set_req(1'b0, 1'b1, 1'b0, 11'h010, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 11'h020, 8'h77);
    wait_grants(base + 4, 60);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    wait_rsps(rsp_cnt + 1, 20);
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (dut_gq.size() > base + i) chk_eq("t3_order", dut_gq[base + i], exp_order[i]);
      else chk_eq("t3_order_missing", i, 99);
      if (i > 0 && dut_gq.size() > base + i)
        chk_eq("t3_spacing", dut_gcyc[base + i] - dut_gcyc[base + i - 1], 4);
    end

    // miss counters and clear-on-completion
    clr_req = 1;
    repeat (2) @(posedge clk); #1;
    l1_val = 1; l2_val = 1;
    send_req(1'b1, 1'b0, 11'h123, 8'h00);
    l1_val = 1; l2_val = 0;
    send_req(1'b0, 1'b0, 11'h124, 8'h00);
    chk_eq("t4_l1", bus.l1_miss_cnt, 2);
    chk_eq("t4_l2", bus.l2_miss_cnt, 1);
    clr_on_done = 1; l1_val = 1; l2_val = 1;
    send_req(1'b0, 1'b0, 11'h125, 8'h00);
    clr_on_done = 0;
    chk_eq("t4_l1_clr", bus.l1_miss_cnt, 0);
    chk_eq("t4_l2_clr", bus.l2_miss_cnt, 0);

    // withheld completion -> timeout
    done_en = 0; l1_val = 0; l2_val = 0;
    send_req(1'b1, 1'b1, 11'h6A2, 8'h3C);
    done_en = 1;
    chk_eq("t5_timeout", bus.timeout, 1);
    chk_eq("t5_rdata", bus.r1_read_data, 8'h00);
    chk_eq("t5_wait_len", dut_rv_cyc - rdy_cyc, MAX_WAIT + 1);
    set_req(1'b0, 1'b1, 1'b0, 11'h001, 8'h00);
    @(negedge clk); #1;
    chk_eq("t5_idle_ready", bus.r0_ready, 1);
    wait_grants(dut_gq.size() + 1, 10);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    wait_rsps(rsp_cnt + 1, 20);

    // reset in the middle of ISSUE
    ready_dly = 6;
    set_req(1'b0, 1'b1, 1'b0, 11'h0F0, 8'h00);
    wait_grants(dut_gq.size() + 1, 20);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk_eq("t1_c_valid_before", bus.c_valid, 1);
    rst_n = 0;
    #1 chk_eq("t1_c_valid_reset", bus.c_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    ready_dly = 0; fix_val = 8'h5A;
    send_req(1'b1, 1'b0, 11'h3FF, 8'h00);
    chk_eq("t1_grant_r1", dut_gq[$], 1);
    chk_eq("t1_rdata", bus.r1_read_data, 8'h5A);
    chk_eq("t1_req_cnt", bus.req_cnt, 1);

    // saturation of the 2-bit counter instance
    do_reset();
    for (int i = 0; i < 5; i++) send_req(1'(i), 1'b0, 11'(i), 8'h00);
    chk_eq("t6_req_cnt", bus.req_cnt, 5);
    chk_eq("t6_req_cnt_sat", bus_s.req_cnt, 3);

    // randomized traffic
    do_reset();
    rnd_mode = 1; stray_en = 1; fix_data = 0; fix_miss = 0;
    acc_flag[0] = 0; acc_flag[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (acc_flag[r]) begin
          acc_flag[r] = 0;
          set_req(1'(r), 1'($urandom), 1'($urandom), 11'($urandom), 8'($urandom));
        end else if (!(r == 0 ? bus.r0_valid : bus.r1_valid) && $urandom_range(0, 2) == 0) begin
          set_req(1'(r), 1'b1, 1'($urandom), 11'($urandom), 8'($urandom));
        end
      end
      if ($urandom_range(0, 49) == 0) clr_req = 1;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    stray_en = 0;
    for (int k = 0; k < 40 && busy; k++) @(posedge clk);
    if (busy) chk_eq("drain_expired", busy, 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
